// File: rtl/stopwatch_fsm.sv
// ============================================================================
// Module  : stopwatch_fsm
// Brief   : Start/stop control FSM; synchronised, debounced push-button toggles run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_fsm #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic ststop,
    output logic run
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   db_q, db_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    state_t                 state_q, state_d;
    logic                   w_s;
    logic                   w_press;

    assign w_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= STOPPED;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ststop};
        db_d    = db_q;
        cnt_d   = '0;
        w_press = 1'b0;
        state_d = state_q;

        // The debounced level only follows s once it has disagreed for a full window.
        if (w_s != db_q) begin
            if (cnt_q == C_CNT_MAX) begin
                db_d    = w_s;
                w_press = w_s;
            end else begin
                cnt_d = cnt_q + C_CNT_ONE;
            end
        end

        case (state_q)
            STOPPED: if (w_press) state_d = RUNNING;
            RUNNING: if (w_press) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    assign run = (state_q == RUNNING);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_fsm.sv
// ============================================================================
// Module  : tb_stopwatch_fsm
// Brief   : Scoreboard bench for stopwatch_fsm with default parameters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_fsm;

    logic clk;
    logic reset;
    logic ststop;
    logic run;

    int   n_checks;
    int   n_errors;
    logic sb_q[$];

    stopwatch_fsm #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .ststop(ststop),
        .run   (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic observed, input logic expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: run=%0b expected %0b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive ststop for one clock, queue the run value expected after the edge,
    // then pop and compare just after that edge.
    task automatic drive_cycle(input string tag, input logic st, input logic exp_run);
        logic exp_v;
        ststop = st;
        sb_q.push_back(exp_run);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        check_eq(tag, run, exp_v);
    endtask

    task automatic drive_n(input string tag, input int n, input logic st, input logic exp_run);
        for (int i = 0; i < n; i++) drive_cycle(tag, st, exp_run);
    endtask

    // ststop held for 4 clocks: run flips on the 4th edge.
    task automatic press4(input string tag, input logic run_before);
        drive_n(tag, 3, 1'b1, run_before);
        drive_cycle(tag, 1'b1, ~run_before);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        ststop   = 1'b0;

        // 1: reset held, then idle
        #1;
        check_eq("reset_init", run, 1'b0);
        drive_n("reset_hold", 2, 1'b0, 1'b0);
        reset = 1'b1;
        drive_n("idle", 3, 1'b0, 1'b0);

        // 2: first press, held longer than the debounce window
        press4("press1", 1'b0);
        drive_n("hold1", 3, 1'b1, 1'b1);

        // 3: release, second press, release, third press
        drive_n("release1", 4, 1'b0, 1'b1);
        press4("press2", 1'b1);
        drive_n("release2", 4, 1'b0, 1'b0);
        press4("press3", 1'b0);
        drive_n("release3", 4, 1'b0, 1'b1);

        // 4: single-clock pulse ignored, two-clock pulse accepted
        drive_cycle("pulse1", 1'b1, 1'b1);
        drive_n("pulse1_after", 6, 1'b0, 1'b1);
        drive_n("pulse2", 2, 1'b1, 1'b1);
        drive_cycle("pulse2_a", 1'b0, 1'b1);
        drive_cycle("pulse2_b", 1'b0, 1'b0);
        drive_n("pulse2_after", 4, 1'b0, 1'b0);

        // 5: asynchronous reset between edges while running
        press4("press4", 1'b0);
        #3;
        reset  = 1'b0;
        ststop = 1'b0;
        #1;
        check_eq("async_reset", run, 1'b0);
        drive_n("reset_low", 2, 1'b0, 1'b0);
        reset = 1'b1;
        drive_n("after_reset", 4, 1'b0, 1'b0);

        // 6: bounce 1,0,1,0 then steady high -> exactly one toggle
        drive_cycle("bounce", 1'b1, 1'b0);
        drive_cycle("bounce", 1'b0, 1'b0);
        drive_cycle("bounce", 1'b1, 1'b0);
        drive_cycle("bounce", 1'b0, 1'b0);
        press4("bounce_settle", 1'b0);
        drive_n("bounce_hold", 4, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
